// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Handles stall hold, branch redirect/flush and HALT detection.
module fetch_stage #(
    parameter logic [31:0]  RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]   HALT_OPCODE = 6'b111111,
    parameter int unsigned  CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e           state_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  instr_q;
    logic [XLEN-1:0]  pc4_q;
    logic             valid_q;
    logic             halted_q;
    logic             misalign_q;
    logic [CNT_W-1:0] count_q;

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  redirect_pc;
    logic             is_halt_word;

    assign pc_plus4     = pc_q + XLEN'(4);
    assign redirect_pc  = {branch_target[31:2], 2'b00};
    assign is_halt_word = (imem_rdata[31:26] == HALT_OPCODE);

    // State and IF/ID register update; branch outranks stall and HALT detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                end
                ST_RUN, ST_HALT: begin
                    if (branch_taken) begin
                        pc_q     <= redirect_pc;
                        instr_q  <= '0;
                        pc4_q    <= '0;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                        state_q  <= ST_RUN;
                        if (branch_target[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                        end
                    end else if (state_q == ST_RUN && !stall) begin
                        if (is_halt_word) begin
                            instr_q  <= '0;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            pc_q    <= pc_plus4;
                            instr_q <= imem_rdata;
                            pc4_q   <= pc_plus4;
                            valid_q <= 1'b1;
                            if (count_q != {CNT_W{1'b1}}) begin
                                count_q <= count_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random stall/branch/reset traffic.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC  = 32'hFFFF_FFFC;
    localparam logic [31:0] HALT_W  = 32'hFC00_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic        misalign_err;
    logic [15:0] fetch_count;

    logic [31:0] rom [256];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        hlt;
        logic        mis;
        logic [15:0] cnt;
    } exp_t;

    exp_t q_exp[$];
    exp_t m;
    int   m_mode;   // 0 boot, 1 run, 2 halt
    int   checks;
    int   errors;
    logic stim_done;

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .HALT_OPCODE(6'b111111),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    assign imem_rdata = rom[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input exp_t e);
        chk("imem_addr", imem_addr, e.pc);
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_pc4", if_id_pc4, e.pc4);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        chk("halted", 32'(halted), 32'(e.hlt));
        chk("misalign_err", 32'(misalign_err), 32'(e.mis));
        chk("fetch_count", 32'(fetch_count), 32'(e.cnt));
    endtask

    function automatic void model_reset();
        m.pc    = RST_PC;
        m.instr = '0;
        m.pc4   = '0;
        m.valid = 1'b0;
        m.hlt   = 1'b0;
        m.mis   = 1'b0;
        m.cnt   = '0;
        m_mode  = 0;
    endfunction

    // Reference behaviour of one clock edge, written directly from the stage rules.
    function automatic void model_edge(input logic st, input logic br, input logic [31:0] tgt);
        logic [31:0] w;
        w = rom[m.pc[9:2]];
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (br) begin
            m.pc    = tgt & 32'hFFFF_FFFC;
            m.instr = 0;
            m.pc4   = 0;
            m.valid = 0;
            m.hlt   = 0;
            if (tgt[1:0] != 0) m.mis = 1;
            m_mode  = 1;
        end else if (m_mode == 2 || st) begin
            // holding
        end else if (w[31:26] == 6'h3F) begin
            m.instr = 0;
            m.valid = 0;
            m.hlt   = 1;
            m_mode  = 2;
        end else begin
            m.instr = w;
            m.pc    = m.pc + 4;
            m.pc4   = m.pc;
            m.valid = 1;
            if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 1;
        end
    endfunction

    task automatic cycle(input logic st, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        reset         = 1'b0;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        model_edge(st, br, tgt);
        q_exp.push_back(m);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset        = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        model_reset();
        #1;
        compare_all(m);
        q_exp.push_back(m);
    endtask

    // Monitor: compare DUT outputs after every edge against the oldest pending expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) compare_all(q_exp.pop_front());
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        stim_done     = 1'b0;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = $urandom & 32'hEFFF_FFFF;
        end
        rom[3] = HALT_W;
        model_reset();

        // Boot, wrap from 0xFFFFFFFC to 0, then fetch until HALT at 0xC.
        apply_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);
        // HALT ignores stall and holds.
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        // Leave HALT via branch to 0x20, then stall twice and resume.
        cycle(1'b0, 1'b1, 32'h20);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        // Branch beats stall.
        cycle(1'b1, 1'b1, 32'h40);
        cycle(1'b0, 1'b0, 32'h0);
        // Misaligned target is aligned and makes the error sticky.
        cycle(1'b0, 1'b1, 32'h22);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
        // Mid-run reset clears everything immediately.
        apply_reset();

        for (int n = 0; n < 3000; n++) begin
            logic        st;
            logic        br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) tgt = 32'h0000_000C;
            if ($urandom_range(0, 199) == 0) apply_reset();
            else cycle(st, br, tgt);
        end

        stim_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: stim_done=%0b expected 1", stim_done);
        $fatal(1, "bench timeout");
    end

endmodule
